cache_line_fill: RTL

Line-fill engine for the 4-way set-associative cache. On a miss it fetches one 32-byte line from backing memory as eight 32-bit beats, critical word first with wrap-around. It forwards the requested byte early and presents the assembled line, with a one-cycle write strobe, to the data array. The byte-select mux reads its 32 byte inputs from that data array.

---
 rtl/cache_line_fill_if.sv | 34 +++
 rtl/cache_line_fill.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cache_line_fill_if.sv
// Bundle of the fill request, memory beat and data-array write signals
// exchanged between the line-fill engine and its surroundings.
interface cache_line_fill_if #(
  parameter int ADDR_W = 16,
  parameter int SET_W  = 3
);
  logic                      fill_req;
  logic [ADDR_W-1:0]         fill_addr;
  logic [1:0]                fill_way;
  logic                      fill_busy;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ack;
  logic [31:0]               mem_rdata;
  logic                      crit_valid;
  logic [7:0]                crit_byte;
  logic                      line_we;
  logic [1:0]                line_way;
  logic [SET_W-1:0]          line_index;
  logic [ADDR_W-6-SET_W:0]   line_tag;
  logic [255:0]              line_data;

  modport slave (
    input  fill_req, fill_addr, fill_way, mem_ack, mem_rdata,
    output fill_busy, mem_req, mem_addr, crit_valid, crit_byte,
           line_we, line_way, line_index, line_tag, line_data
  );

  modport master (
    output fill_req, fill_addr, fill_way, mem_ack, mem_rdata,
    input  fill_busy, mem_req, mem_addr, crit_valid, crit_byte,
           line_we, line_way, line_index, line_tag, line_data
  );
endinterface

// File: rtl/cache_line_fill.sv
// Line-fill engine: fetches a 32-byte line as eight wrapped 32-bit beats,
// critical word first, forwards the requested byte and writes the line.
module cache_line_fill #(
  parameter int ADDR_W = 16,
  parameter int SET_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_line_fill_if.slave  io_fill
);
  localparam int TAG_W  = ADDR_W - 5 - SET_W;
  localparam int BASE_W = ADDR_W - 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_beat;
  logic [2:0]          r_count;
  logic [BASE_W-1:0]   r_base;
  logic [1:0]          r_byte_sel;
  logic [1:0]          r_way;
  logic [SET_W-1:0]    r_index;
  logic [TAG_W-1:0]    r_tag;
  logic [255:0]        r_line;
  logic                r_busy;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_crit_valid;
  logic [7:0]          r_crit_byte;
  logic                r_line_we;

  logic [BASE_W-1:0]   w_req_base;
  logic [2:0]          w_req_beat;
  logic [2:0]          w_next_beat;
  logic [7:0]          w_beat_lsb;
  logic [4:0]          w_crit_lsb;
  logic [7:0]          w_crit_byte;

  assign w_req_base  = io_fill.fill_addr[ADDR_W-1:5];
  assign w_req_beat  = io_fill.fill_addr[4:2];
  assign w_next_beat = r_beat + 3'd1;
  assign w_beat_lsb  = {r_beat, 5'b00000};
  assign w_crit_lsb  = {r_byte_sel, 3'b000};
  assign w_crit_byte = io_fill.mem_rdata[w_crit_lsb +: 8];

  // Fill sequencer: accept, fetch eight wrapped beats, one-cycle line write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= 3'd0;
      r_count      <= 3'd0;
      r_base       <= '0;
      r_byte_sel   <= 2'd0;
      r_way        <= 2'd0;
      r_index      <= '0;
      r_tag        <= '0;
      r_line       <= 256'd0;
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_crit_valid <= 1'b0;
      r_crit_byte  <= 8'd0;
      r_line_we    <= 1'b0;
    end else begin
      r_crit_valid <= 1'b0;
      r_line_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_fill.fill_req) begin
            r_base     <= w_req_base;
            r_beat     <= w_req_beat;
            r_count    <= 3'd0;
            r_byte_sel <= io_fill.fill_addr[1:0];
            r_way      <= io_fill.fill_way;
            r_index    <= io_fill.fill_addr[4+SET_W:5];
            r_tag      <= io_fill.fill_addr[ADDR_W-1:5+SET_W];
            r_line     <= 256'd0;
            r_busy     <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_req_base, w_req_beat, 2'b00};
            r_state    <= ST_FETCH;
          end else begin
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (io_fill.mem_ack) begin
            r_line[w_beat_lsb +: 32] <= io_fill.mem_rdata;
            // Only the first beat of a fill carries the critical word.
            if (r_count == 3'd0) begin
              r_crit_byte  <= w_crit_byte;
              r_crit_valid <= 1'b1;
            end
            r_beat     <= w_next_beat;
            r_count    <= r_count + 3'd1;
            r_mem_addr <= {r_base, w_next_beat, 2'b00};
            if (r_count == 3'd7) begin
              r_mem_req <= 1'b0;
              r_line_we <= 1'b1;
              r_state   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_fill.fill_busy  = r_busy;
  assign io_fill.mem_req    = r_mem_req;
  assign io_fill.mem_addr   = r_mem_addr;
  assign io_fill.crit_valid = r_crit_valid;
  assign io_fill.crit_byte  = r_crit_byte;
  assign io_fill.line_we    = r_line_we;
  assign io_fill.line_way   = r_way;
  assign io_fill.line_index = r_index;
  assign io_fill.line_tag   = r_tag;
  assign io_fill.line_data  = r_line;
endmodule
